// File: rtl/rv_decode_pkg.sv
// Shared RV32I/M decode constants: opcodes, funct fields, op_bus bit positions
// and the instruction format enum.
package rv_decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_B   = 3'd0, F3_H   = 3'd1, F3_W   = 3'd2, F3_BU   = 3'd4, F3_HU = 3'd5;
    localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;

    localparam int OP_ADD = 0,  OP_SUB = 1,  OP_XOR = 2,  OP_OR = 3,  OP_AND = 4;
    localparam int OP_SLL = 5,  OP_SRL = 6,  OP_SRA = 7,  OP_SLT = 8, OP_SLTU = 9;
    localparam int OP_ADDI = 10, OP_XORI = 11, OP_ORI = 12, OP_ANDI = 13, OP_SLLI = 14;
    localparam int OP_SRLI = 15, OP_SRAI = 16, OP_SLTI = 17, OP_SLTIU = 18;
    localparam int OP_LB = 19, OP_LH = 20, OP_LW = 21, OP_LBU = 22, OP_LHU = 23;
    localparam int OP_SB = 24, OP_SH = 25, OP_SW = 26;
    localparam int OP_BEQ = 27, OP_BNE = 28, OP_BLT = 29, OP_BGE = 30, OP_BLTU = 31, OP_BGEU = 32;
    localparam int OP_JAL = 33, OP_JALR = 34, OP_LUI = 35, OP_AUIPC = 36;
    localparam int OP_MUL = 37;
    localparam int OP_BASE_W = 37;
    localparam int OP_ALL_W  = 45;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
    } fmt_e;

endpackage

// File: rtl/decode_stage_comb.sv
// Purely combinational instruction-to-fields decoder for RV32I with optional
// M extension.
module decode_comb
    import rv_decode_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int M_EXT = 0,
    localparam int OP_W  = OP_BASE_W + 8 * M_EXT
) (
    input  logic [31:0]     instr_i,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic            rd_valid_o,
    output logic            rs1_valid_o,
    output logic            rs2_valid_o,
    output logic            imm_valid_o,
    output logic [XLEN-1:0] imm_o,
    output logic [OP_W-1:0] op_bus_o,
    output logic            illegal_o
);
    logic [6:0]             opc;
    logic [2:0]             f3;
    logic [6:0]             f7;
    fmt_e                   fmt;
    logic [OP_ALL_W-1:0]    op_all;
    logic signed [XLEN-1:0] imm_s;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign rd_o  = instr_i[11:7];
    assign rs1_o = instr_i[19:15];
    assign rs2_o = instr_i[24:20];

    always_comb begin
        op_all = '0;
        fmt    = FMT_NONE;
        case (opc)
            OPC_OP: begin
                fmt = FMT_R;
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  op_all[OP_ADD]  = 1'b1;
                        F3_SLL:  op_all[OP_SLL]  = 1'b1;
                        F3_SLT:  op_all[OP_SLT]  = 1'b1;
                        F3_SLTU: op_all[OP_SLTU] = 1'b1;
                        F3_XOR:  op_all[OP_XOR]  = 1'b1;
                        F3_SR:   op_all[OP_SRL]  = 1'b1;
                        F3_OR:   op_all[OP_OR]   = 1'b1;
                        F3_AND:  op_all[OP_AND]  = 1'b1;
                    endcase
                end else if (f7 == F7_ALT) begin
                    op_all[OP_SUB] = (f3 == F3_ADD);
                    op_all[OP_SRA] = (f3 == F3_SR);
                end else if (f7 == F7_MULDIV && M_EXT != 0) begin
                    // mul..remu occupy consecutive bits in funct3 order
                    op_all = OP_ALL_W'(1) << (OP_MUL + int'(f3));
                end
            end
            OPC_OPIMM: begin
                fmt = FMT_I;
                case (f3)
                    F3_ADD:  op_all[OP_ADDI]  = 1'b1;
                    F3_SLT:  op_all[OP_SLTI]  = 1'b1;
                    F3_SLTU: op_all[OP_SLTIU] = 1'b1;
                    F3_XOR:  op_all[OP_XORI]  = 1'b1;
                    F3_OR:   op_all[OP_ORI]   = 1'b1;
                    F3_AND:  op_all[OP_ANDI]  = 1'b1;
                    F3_SLL:  op_all[OP_SLLI]  = (f7 == F7_BASE);
                    F3_SR: begin
                        op_all[OP_SRLI] = (f7 == F7_BASE);
                        op_all[OP_SRAI] = (f7 == F7_ALT);
                    end
                endcase
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                case (f3)
                    F3_B:    op_all[OP_LB]  = 1'b1;
                    F3_H:    op_all[OP_LH]  = 1'b1;
                    F3_W:    op_all[OP_LW]  = 1'b1;
                    F3_BU:   op_all[OP_LBU] = 1'b1;
                    F3_HU:   op_all[OP_LHU] = 1'b1;
                    default: ;
                endcase
            end
            OPC_JALR: begin
                fmt              = FMT_I;
                op_all[OP_JALR]  = (f3 == 3'd0);
            end
            OPC_STORE: begin
                fmt = FMT_S;
                case (f3)
                    F3_B:    op_all[OP_SB] = 1'b1;
                    F3_H:    op_all[OP_SH] = 1'b1;
                    F3_W:    op_all[OP_SW] = 1'b1;
                    default: ;
                endcase
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                case (f3)
                    F3_BEQ:  op_all[OP_BEQ]  = 1'b1;
                    F3_BNE:  op_all[OP_BNE]  = 1'b1;
                    F3_BLT:  op_all[OP_BLT]  = 1'b1;
                    F3_BGE:  op_all[OP_BGE]  = 1'b1;
                    F3_BLTU: op_all[OP_BLTU] = 1'b1;
                    F3_BGEU: op_all[OP_BGEU] = 1'b1;
                    default: ;
                endcase
            end
            OPC_LUI:   begin fmt = FMT_U; op_all[OP_LUI]   = 1'b1; end
            OPC_AUIPC: begin fmt = FMT_U; op_all[OP_AUIPC] = 1'b1; end
            OPC_JAL:   begin fmt = FMT_J; op_all[OP_JAL]   = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        imm_s = '0;
        case (fmt)
            FMT_I:   imm_s = XLEN'($signed(instr_i[31:20]));
            FMT_S:   imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            FMT_B:   imm_s = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                            instr_i[11:8], 1'b0}));
            FMT_U:   imm_s = XLEN'($signed({instr_i[31:12], 12'b0}));
            FMT_J:   imm_s = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                            instr_i[30:21], 1'b0}));
            default: imm_s = '0;
        endcase
    end

    assign imm_o     = imm_s;
    assign op_bus_o  = op_all[OP_W-1:0];
    assign illegal_o = ~|op_bus_o;

    // Register usage is suppressed for illegal words so nothing downstream reads or writes regs
    assign rd_valid_o  = !illegal_o && (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J});
    assign rs1_valid_o = !illegal_o && (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B});
    assign rs2_valid_o = !illegal_o && (fmt inside {FMT_R, FMT_S, FMT_B});
    assign imm_valid_o = (fmt != FMT_R) && (fmt != FMT_NONE);

    if (OP_W < OP_ALL_W) begin : g_trim
        logic unused_m_bits;
        assign unused_m_bits = |op_all[OP_ALL_W-1:OP_W];
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes at the input, then holds results in an
// output register backed by one skid register for full-throughput backpressure.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int M_EXT = 0,
    localparam int OP_W  = OP_BASE_W + 8 * M_EXT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            rd_valid,
    output logic            rs1_valid,
    output logic            rs2_valid,
    output logic            imm_valid,
    output logic [XLEN-1:0] imm,
    output logic [OP_W-1:0] op_bus,
    output logic            illegal
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rd_valid;
        logic            rs1_valid;
        logic            rs2_valid;
        logic            imm_valid;
        logic [XLEN-1:0] imm;
        logic [OP_W-1:0] op_bus;
        logic            illegal;
    } entry_t;

    logic [4:0]      dec_rd, dec_rs1, dec_rs2;
    logic            dec_rdv, dec_rs1v, dec_rs2v, dec_immv, dec_ill;
    logic [XLEN-1:0] dec_imm;
    logic [OP_W-1:0] dec_op;
    entry_t          dec;

    entry_t out_q, out_d, skid_q, skid_d;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic   push, pop;

    decode_comb #(.XLEN(XLEN), .M_EXT(M_EXT)) u_dec (
        .instr_i     (in_instr),
        .rd_o        (dec_rd),
        .rs1_o       (dec_rs1),
        .rs2_o       (dec_rs2),
        .rd_valid_o  (dec_rdv),
        .rs1_valid_o (dec_rs1v),
        .rs2_valid_o (dec_rs2v),
        .imm_valid_o (dec_immv),
        .imm_o       (dec_imm),
        .op_bus_o    (dec_op),
        .illegal_o   (dec_ill)
    );

    always_comb begin
        dec = '{pc: in_pc, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
                rd_valid: dec_rdv, rs1_valid: dec_rs1v, rs2_valid: dec_rs2v,
                imm_valid: dec_immv, imm: dec_imm, op_bus: dec_op, illegal: dec_ill};
    end

    // Ready comes only from the skid flag, keeping out_ready off the in_ready path
    assign in_ready = !skid_valid_q;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (pop) begin
                out_valid_d  = skid_valid_q;
                skid_valid_d = 1'b0;
                if (skid_valid_q) out_d = skid_q;
            end
            if (push) begin
                if (!out_valid_q || pop) begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                end else begin
                    skid_d       = dec;
                    skid_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_q.pc;
    assign rd        = out_q.rd;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign rd_valid  = out_q.rd_valid;
    assign rs1_valid = out_q.rs1_valid;
    assign rs2_valid = out_q.rs2_valid;
    assign imm_valid = out_q.imm_valid;
    assign imm       = out_q.imm;
    assign op_bus    = out_q.op_bus;
    assign illegal   = out_q.illegal;

endmodule
